vga_scanout: RTL and testbench

- Display-side timing engine and pixel sink for the pong frame pipeline.
- Generates raster coordinates px/py for the game pixel source and samples the returned 24-bit pixel.
- Drives VGA DAC outputs: rgb, hsync, vsync, blank_n, sync_n and pixel clock.
- Emits a one-clk frame_tick at frame start, usable as the game update strobe in place of a free-running divider.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_axis_counter.sv | 70 +++++++
 rtl/vga_scanout.sv | 160 ++++++++++++++++
 tb/tb_vga_scanout.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA scanout path: segment encoding,
// the 640x480@60 constant set and line/frame total helpers.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEG_ACT  = 2'd0,
    SEG_FP   = 2'd1,
    SEG_SYNC = 2'd2,
    SEG_BP   = 2'd3
  } seg_state_e;

  // One pixel's worth of timing, carried down the delay pipeline (active-high).
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } timing_t;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic seg_state_e next_seg(seg_state_e s);
    case (s)
      SEG_ACT:  return SEG_FP;
      SEG_FP:   return SEG_SYNC;
      SEG_SYNC: return SEG_BP;
      default:  return SEG_ACT;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus an ACT/FP/SYNC/BP segment
// FSM whose per-segment down-counter reloads on entry and advances at zero.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] count,
  output seg_state_e state,
  output logic       wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segment
    $error("vga_axis_counter: every segment must be at least one unit long");
  end

  function automatic logic [9:0] seg_last(seg_state_e s);
    case (s)
      SEG_ACT:  return 10'(ACTIVE - 1);
      SEG_FP:   return 10'(FP - 1);
      SEG_SYNC: return 10'(SYNC - 1);
      default:  return 10'(BP - 1);
    endcase
  endfunction

  logic [9:0] cnt_q, cnt_d;
  logic [9:0] seg_q, seg_d;
  seg_state_e state_q, state_d;

  assign wrap  = step && (cnt_q == LAST);
  assign count = cnt_q;
  assign state = state_q;

  always_comb begin
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    state_d = state_q;
    if (step) begin
      cnt_d = wrap ? 10'd0 : cnt_q + 10'd1;
      if (seg_q == 10'd0) begin
        state_d = next_seg(state_q);
        seg_d   = seg_last(state_d);
      end else begin
        seg_d = seg_q - 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 10'd0;
      seg_q   <= seg_last(SEG_ACT);
      state_q <= SEG_ACT;
    end else begin
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA timing engine and pixel sink: divides clk to the pixel rate, scans px/py,
// and aligns the returned pixel with delayed sync/blank on the DAC outputs.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  px,
  output logic [9:0]  py,
  input  logic [23:0] pixel,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_tick,
  output logic        line_tick
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_scanout: H_TOTAL exceeds the 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_scanout: V_TOTAL exceeds the 10-bit counter range");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_scanout: CLK_DIV must be at least 2");
  end
  if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_pipe_lat
    $error("vga_scanout: PIPE_LAT must be within 1..4");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       h_cnt, v_cnt;
  seg_state_e       h_state, v_state;
  logic             h_wrap, v_wrap;

  assign pix_en = (div_q == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .reset(reset), .step(pix_en),
    .count(h_cnt), .state(h_state), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .reset(reset), .step(h_wrap),
    .count(v_cnt), .state(v_state), .wrap(v_wrap)
  );

  timing_t     pipe_q [PIPE_LAT];
  timing_t     pipe_d [PIPE_LAT];
  timing_t     tap;
  logic [9:0]  px_q, px_d, py_q, py_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_n_q, hs_n_d, vs_n_q, vs_n_d, blank_n_q, blank_n_d;
  logic        sync_n_q, sync_n_d, vga_clk_q, vga_clk_d;
  logic        line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;

  assign tap = pipe_q[PIPE_LAT-1];

  // Timing enters the pipe alongside px/py, so the tap lines up with the pixel
  // the source returns PIPE_LAT periods later.
  always_comb begin
    pipe_d       = pipe_q;
    div_d        = pix_en ? '0 : div_q + DIV_W'(1);
    px_d         = px_q;
    py_d         = py_q;
    rgb_d        = rgb_q;
    hs_n_d       = hs_n_q;
    vs_n_d       = vs_n_q;
    blank_n_d    = blank_n_q;
    sync_n_d     = 1'b0;
    vga_clk_d    = (div_d >= DIV_HALF);
    line_tick_d  = h_wrap;
    frame_tick_d = v_wrap;
    if (pix_en) begin
      pipe_d[0].hs     = (h_state == SEG_SYNC);
      pipe_d[0].vs     = (v_state == SEG_SYNC);
      pipe_d[0].active = (h_state == SEG_ACT) && (v_state == SEG_ACT);
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      px_d      = h_cnt;
      py_d      = v_cnt;
      rgb_d     = tap.active ? pixel : 24'd0;
      hs_n_d    = ~tap.hs;
      vs_n_d    = ~tap.vs;
      blank_n_d = tap.active;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      div_q        <= '0;
      px_q         <= 10'd0;
      py_q         <= 10'd0;
      rgb_q        <= 24'd0;
      hs_n_q       <= 1'b1;
      vs_n_q       <= 1'b1;
      blank_n_q    <= 1'b0;
      sync_n_q     <= 1'b0;
      vga_clk_q    <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pipe_q       <= pipe_d;
      div_q        <= div_d;
      px_q         <= px_d;
      py_q         <= py_d;
      rgb_q        <= rgb_d;
      hs_n_q       <= hs_n_d;
      vs_n_q       <= vs_n_d;
      blank_n_q    <= blank_n_d;
      sync_n_q     <= sync_n_d;
      vga_clk_q    <= vga_clk_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign px          = px_q;
  assign py          = py_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs      = hs_n_q;
  assign vga_vs      = vs_n_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = sync_n_q;
  assign vga_clk     = vga_clk_q;
  assign line_tick   = line_tick_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-raster instance (PIPE_LAT=2) for pipeline,
// vertical and frame checks, and a full 640x480 instance for horizontal timing.
module tb_vga_scanout;

  localparam int SH_A = 8, SH_FP = 2, SH_S = 3, SH_BP = 2, SH_T = 15;
  localparam int SV_A = 4, SV_FP = 1, SV_S = 2, SV_BP = 1, SV_T = 8;
  localparam int S_LAT = 2;
  localparam int S_FRAME_CLK = 2 * SH_T * SV_T;
  localparam logic [50:0] RESET_STATE =
    {10'd0, 10'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef struct packed {
    logic [23:0] rgb;
    logic        blank_n;
    logic        hs_n;
    logic        vs_n;
    logic        sync_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] s_pixel = 24'd0, d_pixel = 24'd0;
  logic [9:0] s_px, s_py, d_px, d_py;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic s_hs, s_vs, s_blank_n, s_sync_n, s_vga_clk, s_frame_tick, s_line_tick;
  logic d_hs, d_vs, d_blank_n, d_sync_n, d_vga_clk, d_frame_tick, d_line_tick;
  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else n <= n + 1;
  end

  vga_scanout #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
    .CLK_DIV(2), .PIPE_LAT(S_LAT)
  ) dut_small (
    .clk(clk), .reset(reset), .px(s_px), .py(s_py), .pixel(s_pixel),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_blank_n), .vga_sync_n(s_sync_n), .vga_clk(s_vga_clk),
    .frame_tick(s_frame_tick), .line_tick(s_line_tick)
  );

  vga_scanout dut_std (
    .clk(clk), .reset(reset), .px(d_px), .py(d_py), .pixel(d_pixel),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
    .vga_blank_n(d_blank_n), .vga_sync_n(d_sync_n), .vga_clk(d_vga_clk),
    .frame_tick(d_frame_tick), .line_tick(d_line_tick)
  );

  wire [50:0] s_all = {s_px, s_py, s_r, s_g, s_b, s_hs, s_vs, s_blank_n,
                       s_sync_n, s_vga_clk, s_frame_tick, s_line_tick};
  wire [50:0] d_all = {d_px, d_py, d_r, d_g, d_b, d_hs, d_vs, d_blank_n,
                       d_sync_n, d_vga_clk, d_frame_tick, d_line_tick};

  // Closed-form raster model for the small instance, indexed by pixel number j.
  function automatic exp_t s_expect(int j, logic [23:0] pix);
    int hx = j % SH_T;
    int vy = (j / SH_T) % SV_T;
    exp_t e;
    e.blank_n = (hx < SH_A) && (vy < SV_A);
    e.hs_n    = !((hx >= SH_A + SH_FP) && (hx < SH_A + SH_FP + SH_S));
    e.vs_n    = !((vy >= SV_A + SV_FP) && (vy < SV_A + SV_FP + SV_S));
    e.sync_n  = 1'b0;
    e.rgb     = e.blank_n ? pix : 24'd0;
    return e;
  endfunction

  function automatic logic [23:0] s_encode(int j);
    logic [7:0] hx = 8'((j % SH_T));
    logic [7:0] vy = 8'(((j / SH_T) % SV_T));
    return {hx, vy, 8'h5A};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_all !== RESET_STATE) begin
      miscompares++;
      $display("[TB] FAIL reset_small: got %h expected %h", s_all, RESET_STATE);
    end
    vectors++;
    if (d_all !== RESET_STATE) begin
      miscompares++;
      $display("[TB] FAIL reset_std: got %h expected %h", d_all, RESET_STATE);
    end
  endtask

  task automatic test_pipeline();
    exp_t q[$];
    exp_t e, got;
    int k;
    logic exp_lt, exp_ft;
    s_pixel = 24'd0;
    do_reset();
    for (int c = 0; c < 2 * S_FRAME_CLK + 8; c++) begin
      @(negedge clk);
      k = n / 2;
      exp_lt = (n % 2 == 0) && (k % SH_T == 0);
      exp_ft = (n % 2 == 0) && (k % (SH_T * SV_T) == 0);
      vectors++;
      if ({s_vga_clk, s_line_tick, s_frame_tick} !== {logic'(n % 2), exp_lt, exp_ft}) begin
        miscompares++;
        $display("[TB] FAIL clk_ticks n=%0d: got %b expected %b", n,
                 {s_vga_clk, s_line_tick, s_frame_tick}, {logic'(n % 2), exp_lt, exp_ft});
      end
      if (n % 2 == 0) begin
        vectors++;
        if ({s_px, s_py} !== {10'((k - 1) % SH_T), 10'(((k - 1) / SH_T) % SV_T)}) begin
          miscompares++;
          $display("[TB] FAIL coord k=%0d: got %0d,%0d expected %0d,%0d", k, s_px, s_py,
                   (k - 1) % SH_T, ((k - 1) / SH_T) % SV_T);
        end
        if (k > S_LAT) e = q.pop_front();
        else e = '{rgb: 24'd0, blank_n: 1'b0, hs_n: 1'b1, vs_n: 1'b1, sync_n: 1'b0};
        got = '{rgb: {s_r, s_g, s_b}, blank_n: s_blank_n, hs_n: s_hs, vs_n: s_vs, sync_n: s_sync_n};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("[TB] FAIL pipe_out k=%0d: got %h expected %h", k, got, e);
        end
        if (k >= S_LAT) begin
          s_pixel = s_encode(k - S_LAT);
          q.push_back(s_expect(k - S_LAT, s_encode(k - S_LAT)));
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [23:0] q[$];
    logic [23:0] e;
    int k;
    s_pixel = 24'h123456;
    do_reset();
    for (int c = 0; c < S_FRAME_CLK + 8; c++) begin
      @(negedge clk);
      k = n / 2;
      if (n % 2 == 0) begin
        if (k > S_LAT) begin
          e = q.pop_front();
          vectors++;
          if ({s_r, s_g, s_b} !== e) begin
            miscompares++;
            $display("[TB] FAIL blank_rgb k=%0d: got %h expected %h", k, {s_r, s_g, s_b}, e);
          end
        end
        if (k >= S_LAT) q.push_back(s_expect(k - S_LAT, 24'h123456).rgb);
      end
    end
  endtask

  task automatic test_hsync_default();
    int n_blank = -1, n_px656 = -1, n_fall = -1, n_rise = -1, n_ft = 0;
    int ticks[$];
    logic prev_hs = 1'b1;
    d_pixel = 24'hFFFFFF;
    do_reset();
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (d_blank_n && n_blank < 0) n_blank = n;
      if (d_px == 10'd656 && n_px656 < 0) n_px656 = n;
      if (prev_hs && !d_hs && n_fall < 0) n_fall = n;
      if (!prev_hs && d_hs && n_fall >= 0 && n_rise < 0) n_rise = n;
      prev_hs = d_hs;
      if (d_line_tick) ticks.push_back(n);
      if (d_frame_tick) n_ft++;
      vectors++;
      if ({d_r, d_g, d_b} !== (d_blank_n ? 24'hFFFFFF : 24'd0)) begin
        miscompares++;
        $display("[TB] FAIL std_rgb n=%0d: got %h with blank_n=%b", n, {d_r, d_g, d_b}, d_blank_n);
      end
    end
    vectors++;
    if (n_blank != 4) begin
      miscompares++;
      $display("[TB] FAIL blank_rise: got clk %0d expected 4", n_blank);
    end
    vectors++;
    if (n_fall - n_px656 != 2) begin
      miscompares++;
      $display("[TB] FAIL hs_fall_delay: got %0d expected 2", n_fall - n_px656);
    end
    vectors++;
    if (n_rise - n_fall != 192) begin
      miscompares++;
      $display("[TB] FAIL hs_width: got %0d expected 192", n_rise - n_fall);
    end
    vectors++;
    if (ticks.size() != 2 || ticks[0] != 1600 || ticks[1] - ticks[0] != 1600) begin
      miscompares++;
      $display("[TB] FAIL line_tick_period: got %0d ticks first at %0d expected 2 at 1600,3200",
               ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
    end
    vectors++;
    if (n_ft != 0) begin
      miscompares++;
      $display("[TB] FAIL std_no_frame_tick: got %0d expected 0", n_ft);
    end
  endtask

  task automatic test_async_reset();
    int first_sft = -1, first_dlt = -1;
    d_pixel = 24'hFFFFFF;
    s_pixel = 24'h00FF00;
    do_reset();
    for (int c = 0; c < 1000 && d_px != 10'd300; c++) @(negedge clk);
    vectors++;
    if (d_px !== 10'd300) begin
      miscompares++;
      $display("[TB] FAIL wait_px300: got %0d expected 300", d_px);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (s_all !== RESET_STATE) begin
      miscompares++;
      $display("[TB] FAIL async_small: got %h expected %h", s_all, RESET_STATE);
    end
    vectors++;
    if (d_all !== RESET_STATE) begin
      miscompares++;
      $display("[TB] FAIL async_std: got %h expected %h", d_all, RESET_STATE);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      if (n == 2 || n == 4) begin
        vectors++;
        if ({s_px, s_py, d_px, d_py} !== {10'(n / 2 - 1), 10'd0, 10'(n / 2 - 1), 10'd0}) begin
          miscompares++;
          $display("[TB] FAIL restart_coord n=%0d: got %0d,%0d %0d,%0d expected %0d,0",
                   n, s_px, s_py, d_px, d_py, n / 2 - 1);
        end
      end
      if (s_frame_tick && first_sft < 0) first_sft = n;
      if (d_line_tick && first_dlt < 0) first_dlt = n;
    end
    vectors++;
    if (first_sft != S_FRAME_CLK) begin
      miscompares++;
      $display("[TB] FAIL first_frame_tick: got %0d expected %0d", first_sft, S_FRAME_CLK);
    end
    vectors++;
    if (first_dlt != 1600) begin
      miscompares++;
      $display("[TB] FAIL first_line_tick: got %0d expected 1600", first_dlt);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_blanking();
    test_hsync_default();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
